// File: rtl/jtframe_zxdos_joy_pkg.sv
// Shared definitions for the ZXDOS serial joystick chain: slot numbering of the
// 26-slot scan frame and the slot -> (player, button bit) map.
package jtframe_zxdos_joy_pkg;

   localparam int LOAD_SLOT      = 0;
   localparam int FIRST_BIT_SLOT = 2;
   localparam int LAST_SLOT      = 25;
   localparam int NSLOTS         = 26;
   localparam int NBITS          = NSLOTS - FIRST_BIT_SLOT;   // 24 button bits per frame

   // Destination of one serial slot: player 0 = joystick1, player 1 = joystick2
   typedef struct packed {
      logic       player;
      logic [3:0] bit_idx;
   } joy_dest_t;

   // Slot -> button bit map of the external shift register chain
   function automatic joy_dest_t slot_dest(input int slot);
      joy_dest_t d;
      d = '{player: 1'b0, bit_idx: 4'd0};
      case (slot)
         2:  d = '{1'b0, 4'd8};    // start
         3:  d = '{1'b0, 4'd6};
         4:  d = '{1'b0, 4'd5};
         5:  d = '{1'b0, 4'd4};
         6:  d = '{1'b0, 4'd0};    // right
         7:  d = '{1'b0, 4'd1};    // left
         8:  d = '{1'b0, 4'd2};    // down
         9:  d = '{1'b0, 4'd3};    // up
         10: d = '{1'b1, 4'd8};
         11: d = '{1'b1, 4'd6};
         12: d = '{1'b1, 4'd5};
         13: d = '{1'b1, 4'd4};
         14: d = '{1'b1, 4'd0};
         15: d = '{1'b1, 4'd1};
         16: d = '{1'b1, 4'd2};
         17: d = '{1'b1, 4'd3};
         18: d = '{1'b1, 4'd10};
         19: d = '{1'b1, 4'd11};
         20: d = '{1'b1, 4'd9};    // coin
         21: d = '{1'b1, 4'd7};
         22: d = '{1'b0, 4'd10};
         23: d = '{1'b0, 4'd11};
         24: d = '{1'b0, 4'd9};    // coin
         25: d = '{1'b0, 4'd7};
         default: d = '{1'b0, 4'd0};
      endcase
      return d;
   endfunction

endpackage

// File: rtl/jtframe_zxdos_joysync.sv
// Two-flop synchroniser for the asynchronous joystick serial data line.
// Resets to 1 so an idle (released) line is seen while the chain restarts.
module jtframe_zxdos_joysync (
   input  logic rst,
   input  logic clk_sys,
   input  logic din,
   output logic dout
);

   logic meta;

   // Two register stages; only dout is used by downstream logic
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         meta <= 1'b1;
         dout <= 1'b1;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end

endmodule

// File: rtl/jtframe_zxdos_joyscan.sv
// ZXDOS serial joystick scanner: drives the external PISO chain, deserialises
// a 24-bit active-low frame, debounces it over whole frames and presents
// active-high joystick words that only change between frames.
module jtframe_zxdos_joyscan
   import jtframe_zxdos_joy_pkg::*;
#(
   parameter int DIV_W      = 8,
   parameter int DEB_FRAMES = 2
) (
   input  logic        rst,
   input  logic        clk_sys,
   input  logic        JOY_DATA,
   output logic        JOY_CLK,
   output logic        JOY_LOAD,
   output logic [15:0] joystick1,
   output logic [15:0] joystick2,
   output logic        frame_done
);

   localparam logic [DIV_W-1:0] RISE_VAL = {1'b0, {(DIV_W-1){1'b1}}};
   localparam logic [2:0]       DEB      = 3'(DEB_FRAMES);

   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] div_inc;
   logic [4:0]       slot;
   logic [4:0]       slot_next;
   logic             rise_tick;
   logic             sync_bit;
   logic [NBITS-1:0] raw;
   logic [NBITS-1:0] prev;
   logic [2:0]       stable_cnt;
   logic [2:0]       cnt_next;
   logic [15:0]      j1_map;
   logic [15:0]      j2_map;
   joy_dest_t        dest;

   jtframe_zxdos_joysync u_sync (
      .rst     (rst),
      .clk_sys (clk_sys),
      .din     (JOY_DATA),
      .dout    (sync_bit)
   );

   assign div_inc   = div + DIV_W'(1);
   assign rise_tick = (div == RISE_VAL);
   assign slot_next = !rise_tick ? slot :
                      (slot == 5'(LAST_SLOT)) ? 5'd0 : slot + 5'd1;

   // Debounce counter: restart on any difference, saturate at DEB on repeats
   assign cnt_next = (raw != prev)      ? 3'd1 :
                     (stable_cnt >= DEB) ? DEB  : stable_cnt + 3'd1;

   // Free-running divider; JOY_CLK is its registered MSB
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         div     <= '0;
         JOY_CLK <= 1'b0;
      end else begin
         div     <= div_inc;
         JOY_CLK <= div_inc[DIV_W-1];
      end
   end

   // Slot sequencing and the active-low parallel-load strobe held for slot 0
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         slot     <= 5'd0;
         JOY_LOAD <= 1'b1;
      end else begin
         slot     <= slot_next;
         JOY_LOAD <= (slot_next != 5'(LOAD_SLOT));
      end
   end

   // Capture the synchronised bit for the slot that ends on this rise tick
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         raw <= '1;
      end else begin
         for (int i = 0; i < NBITS; i++) begin
            if (rise_tick && slot == 5'(i + FIRST_BIT_SLOT))
               raw[i] <= sync_bit;
         end
      end
   end

   // Reorder the raw frame into active-high joystick words
   always_comb begin
      j1_map = '0;
      j2_map = '0;
      dest   = '0;
      for (int i = 0; i < NBITS; i++) begin
         dest = slot_dest(i + FIRST_BIT_SLOT);
         if (dest.player)
            j2_map[dest.bit_idx] = ~raw[i];
         else
            j1_map[dest.bit_idx] = ~raw[i];
      end
   end

   // Frame end: pulse frame_done the cycle after the last capture, then
   // compare frames and publish once DEB consecutive frames agree
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         frame_done <= 1'b0;
         prev       <= '1;
         stable_cnt <= 3'd0;
         joystick1  <= 16'h0000;
         joystick2  <= 16'h0000;
      end else begin
         frame_done <= rise_tick && (slot == 5'(LAST_SLOT));
         if (frame_done) begin
            stable_cnt <= cnt_next;
            prev       <= raw;
            if (cnt_next == DEB) begin
               joystick1 <= j1_map;
               joystick2 <= j2_map;
            end
         end
      end
   end

endmodule
